instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests 4-word lines from the instruction memory and
// streams single 32-bit instructions to decode over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              FETCH_EN,
   output logic [ADDR_W-1:0] ADDRESS,
   input  logic [127:0]      INSTRUCTION_SET,
   output logic [31:0]       INSTR,
   output logic [ADDR_W-1:0] INSTR_PC,
   output logic              INSTR_VALID,
   input  logic              INSTR_READY,
   input  logic              BRANCH_TAKEN,
   input  logic [ADDR_W-1:0] BRANCH_TARGET
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_SERVE   = 2'd3
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_inc_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [127:0]        line_q;
   logic [31:0]         instr_q;
   logic [ADDR_W-1:0]   instr_pc_q;
   logic                valid_q;
   logic                last_word_d;

   function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] idx);
      return line[{idx, 5'd0} +: 32];
   endfunction

   assign pc_inc_d    = pc_q + ADDR_W'(1);
   assign last_word_d = (pc_q[1:0] == 2'd3);

   // Single-process FSM; a redirect overrides every state, an in-flight line is
   // dropped simply by re-entering ISSUE with the new line address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= line_of(RESET_PC);
         line_q     <= '0;
         instr_q    <= '0;
         instr_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
      end else if (BRANCH_TAKEN) begin
         pc_q    <= BRANCH_TARGET;
         valid_q <= 1'b0;
         if (FETCH_EN) begin
            state_q <= S_ISSUE;
            addr_q  <= line_of(BRANCH_TARGET);
         end else begin
            state_q <= S_IDLE;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (FETCH_EN) begin
                  state_q <= S_ISSUE;
                  addr_q  <= line_of(pc_q);
               end
            end
            S_ISSUE: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               line_q     <= INSTRUCTION_SET;
               instr_q    <= word_of(INSTRUCTION_SET, pc_q[1:0]);
               instr_pc_q <= pc_q;
               valid_q    <= 1'b1;
               state_q    <= S_SERVE;
            end
            S_SERVE: begin
               if (INSTR_READY) begin
                  pc_q <= pc_inc_d;
                  if (!last_word_d) begin
                     instr_q    <= word_of(line_q, pc_inc_d[1:0]);
                     instr_pc_q <= pc_inc_d;
                  end else begin
                     valid_q <= 1'b0;
                     if (FETCH_EN) begin
                        state_q <= S_ISSUE;
                        addr_q  <= line_of(pc_inc_d);
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ADDRESS     = addr_q;
   assign INSTR       = instr_q;
   assign INSTR_PC    = instr_pc_q;
   assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run checked against an instruction-stream reference model.
module tb_instr_fetch_unit;

   logic         clk;
   logic         rst_n;
   logic         FETCH_EN;
   logic [31:0]  ADDRESS;
   logic [127:0] INSTRUCTION_SET;
   logic [31:0]  INSTR;
   logic [31:0]  INSTR_PC;
   logic         INSTR_VALID;
   logic         INSTR_READY;
   logic         BRANCH_TAKEN;
   logic [31:0]  BRANCH_TARGET;

   int unsigned  n_cmp;
   int unsigned  n_mis;
   logic [31:0]  exp_pc;
   int unsigned  streak;
   logic [31:0]  acc[$];

   instr_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'd6)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .FETCH_EN        (FETCH_EN),
      .ADDRESS         (ADDRESS),
      .INSTRUCTION_SET (INSTRUCTION_SET),
      .INSTR           (INSTR),
      .INSTR_PC        (INSTR_PC),
      .INSTR_VALID     (INSTR_VALID),
      .INSTR_READY     (INSTR_READY),
      .BRANCH_TAKEN    (BRANCH_TAKEN),
      .BRANCH_TARGET   (BRANCH_TARGET)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memw(input logic [31:0] a);
      return 32'hA000_0000 + a;
   endfunction

   // Registered-read instruction memory
   always @(posedge clk)
      INSTRUCTION_SET <= {memw(ADDRESS + 32'd3), memw(ADDRESS + 32'd2),
                          memw(ADDRESS + 32'd1), memw(ADDRESS)};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      FETCH_EN = 1'b0; INSTR_READY = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", INSTR_VALID, 1'b0);
      chk("rst_addr",  ADDRESS, 32'd4);
      chk("rst_instr", INSTR, 32'd0);
      chk("rst_pc",    INSTR_PC, 32'd6);
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 32'd6;
      streak = 0;
      acc.delete();
   endtask

   // One clock: drive inputs, let the edge happen, then check the stream model.
   task automatic cyc(input logic fe, input logic rdy, input logic br, input logic [31:0] tgt);
      logic        pv;
      logic [31:0] ppc;
      pv  = INSTR_VALID;
      ppc = INSTR_PC;
      FETCH_EN = fe; INSTR_READY = rdy; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
      @(posedge clk);
      @(negedge clk);
      if (pv && rdy) acc.push_back(ppc);
      if (br) exp_pc = tgt;
      else if (pv && rdy) exp_pc = exp_pc + 32'd1;
      if (br || !fe || INSTR_VALID) streak = 0;
      else streak++;
      if (!INSTR_VALID) chk("max_gap", streak <= 2, 1'b1);
      if (br) chk("br_drops_valid", INSTR_VALID, 1'b0);
      else if (pv && !rdy) chk("hold_valid", INSTR_VALID, 1'b1);
      else if (pv && rdy) chk("bubble", INSTR_VALID, ppc[1:0] != 2'd3);
      if (INSTR_VALID) begin
         chk("stream_pc",   INSTR_PC, exp_pc);
         chk("stream_data", INSTR, memw(exp_pc));
         chk("stream_addr", ADDRESS, {exp_pc[31:2], 2'b00});
      end
   endtask

   initial begin
      int unsigned t1_pc[11] = '{0, 0, 6, 7, 0, 0, 8, 9, 10, 11, 0};
      int unsigned t1_ad[11] = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8, 12};
      int unsigned n10;
      n_cmp = 0; n_mis = 0;
      FETCH_EN = 1'b0; INSTR_READY = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      do_reset();

      // 1: sequential fetch with line crossing
      for (int k = 0; k < 11; k++) begin
         cyc(1'b1, 1'b1, 1'b0, '0);
         chk("t1_valid", INSTR_VALID, t1_pc[k] != 0);
         if (t1_pc[k] != 0) chk("t1_pc", INSTR_PC, t1_pc[k]);
         chk("t1_addr", ADDRESS, t1_ad[k]);
      end

      // 2: backpressure at PC 8
      do_reset();
      for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t2_pc8", INSTR_PC, 32'd8);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b0, 1'b0, '0);
         chk("t2_hold_pc", INSTR_PC, 32'd8);
         chk("t2_hold_instr", INSTR, 32'hA000_0008);
      end
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t2_next_pc", INSTR_PC, 32'd9);
      chk("t2_acc_n", acc.size(), 3);
      chk("t2_acc_last", acc[2], 32'd8);

      // 3: redirect while PC 9 is stalled
      cyc(1'b1, 1'b0, 1'b1, 32'h21);
      chk("t3_addr", ADDRESS, 32'h20);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t3_gap", INSTR_VALID, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t3_valid", INSTR_VALID, 1'b1);
      chk("t3_pc", INSTR_PC, 32'h21);
      chk("t3_instr", INSTR, 32'hA000_0021);
      chk("t3_no_pc9", acc.size(), 3);

      // 4: redirect coincident with the PC 10 handshake
      do_reset();
      for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t4_pc10", INSTR_PC, 32'd10);
      cyc(1'b1, 1'b1, 1'b1, 32'h40);
      chk("t4_addr", ADDRESS, 32'h40);
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t4_pc", INSTR_PC, 32'h40);
      n10 = 0;
      foreach (acc[i]) if (acc[i] == 32'd10) n10++;
      chk("t4_pc10_once", n10, 1);
      chk("t4_acc_last", acc[acc.size()-1], 32'd10);

      // 5: fetch enable dropped mid-line
      do_reset();
      for (int k = 0; k < 13; k++) cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t5_pc12", INSTR_PC, 32'd12);
      for (int k = 13; k <= 15; k++) begin
         cyc(1'b0, 1'b1, 1'b0, '0);
         chk("t5_drain", INSTR_PC, 32'(k));
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 1'b0, '0);
         chk("t5_idle", INSTR_VALID, 1'b0);
         chk("t5_idle_addr", ADDRESS, 32'd12);
      end
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t5_addr16", ADDRESS, 32'd16);
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t5_pc16", INSTR_PC, 32'd16);

      // 6: reset during CAPTURE, then wrap-around
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 1'b1, 1'b0, '0);
         chk("t6_no_stale", INSTR_VALID, 1'b0);
      end
      cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      chk("t6_addr_top", ADDRESS, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t6_pc_top", INSTR_PC, 32'hFFFF_FFFF);
      chk("t6_instr_top", INSTR, 32'h9FFF_FFFF);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t6_addr0", ADDRESS, 32'd0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, '0);
      chk("t6_pc0", INSTR_PC, 32'd0);
      chk("t6_instr0", INSTR, 32'hA000_0000);

      // Randomized traffic against the stream model
      for (int k = 0; k < 3000; k++) begin
         logic        fe, rdy, br;
         logic [31:0] tgt;
         fe  = ($urandom % 8) != 0;
         rdy = ($urandom % 4) != 0;
         br  = ($urandom % 25) == 0;
         tgt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : 32'($urandom);
         if (($urandom % 400) == 0) do_reset();
         else cyc(fe, rdy, br, tgt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
